// File: rtl/alu_pkg.sv
// Shared opcode map, scheduler FSM encoding and opcode-class helpers for the alu
// and its front-end scheduler alu_sched.
package alu_pkg;

    localparam logic [7:0] OP_DEC      = 8'h01;
    localparam logic [7:0] OP_INC      = 8'h02;
    localparam logic [7:0] OP_NOT      = 8'h03;
    localparam logic [7:0] OP_SETC     = 8'h04;
    localparam logic [7:0] OP_CLRC     = 8'h05;
    localparam logic [7:0] OP_RL       = 8'h06;
    localparam logic [7:0] OP_RR       = 8'h07;
    localparam logic [7:0] OP_RLC      = 8'h08;
    localparam logic [7:0] OP_RRC      = 8'h09;
    localparam logic [7:0] OP_SWAP     = 8'h0A;
    localparam logic [7:0] OP_ADD_L2W  = 8'h88;
    localparam logic [7:0] OP_ADD_M2W  = 8'h8A;
    localparam logic [7:0] OP_SUB_L2W  = 8'h8C;
    localparam logic [7:0] OP_SUB_M2W  = 8'h8E;
    localparam logic [7:0] OP_MUL_L2W  = 8'h90;
    localparam logic [7:0] OP_MUL_M2W  = 8'h92;
    localparam logic [7:0] OP_AND_L2W  = 8'h94;
    localparam logic [7:0] OP_AND_M2W  = 8'h96;
    localparam logic [7:0] OP_OR_L2W   = 8'h98;
    localparam logic [7:0] OP_OR_M2W   = 8'h9A;
    localparam logic [7:0] OP_XOR_L2W  = 8'h9C;
    localparam logic [7:0] OP_XOR_M2W  = 8'h9E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } sched_state_t;

    function automatic logic is_mul(input logic [7:0] op);
        return (op >= 8'h90) && (op <= 8'h93);
    endfunction

    // Only these opcodes define the architectural carry; everything else preserves it.
    function automatic logic sets_carry(input logic [7:0] op);
        return ((op >= 8'h88) && (op <= 8'h8B)) ||
               (op == OP_INC)  || (op == OP_SETC) || (op == OP_CLRC) ||
               (op == OP_RLC)  || (op == OP_RRC);
    endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between the two requesters and alu_sched.
// master = requester side, slave = scheduler side.
interface alu_sched_if;

    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_op;
    logic [7:0] req0_a;
    logic [7:0] req0_b;

    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_op;
    logic [7:0] req1_a;
    logic [7:0] req1_b;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_l;
    logic [7:0] rsp_h;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_sign;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_l, rsp_h, rsp_carry, rsp_zero, rsp_sign,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_l, rsp_h, rsp_carry, rsp_zero, rsp_sign,
        input  rsp_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last winner; on a
// contest the other port wins. Reset pointer = 1 so port 0 wins the first contest.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
            if (|req) begin
                ptr_d = gnt[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational alu between two requesters.
// Optional macro ALU_SCHED_PORT_CARRY_EN gives each port its own carry register.
module alu_sched
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int MUL_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    alu_sched_if.slave  bus,
    output logic        alu_rst,
    output logic        alu_en,
    output logic [7:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    input  logic [7:0]  alu_res_l,
    input  logic [7:0]  alu_res_h,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_sign
);

    localparam int CNT_W = 8;

    sched_state_t      state_q, state_d;
    logic [7:0]        op_q, op_d, a_q, a_d, b_q, b_d;
    logic              id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              alu_rst_q, alu_rst_d, alu_en_q, alu_en_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [7:0]        rsp_l_q, rsp_l_d, rsp_h_q, rsp_h_d;
    logic              rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d;
    logic              rsp_sign_q, rsp_sign_d;
    logic [1:0]        gnt;
    logic              grant_en;
    logic              last_exec;

    assign grant_en  = (state_q == ST_IDLE) && !rst;
    assign last_exec = (state_q == ST_EXEC) && (cnt_q <= CNT_W'(1));

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (grant_en),
        .req ({bus.req1_valid, bus.req0_valid}),
        .gnt (gnt)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

`ifdef ALU_SCHED_PORT_CARRY_EN
    logic [1:0] carry_q, carry_d;

    assign alu_cin = carry_q[id_q];

    always_comb begin
        carry_d = carry_q;
        if (last_exec && sets_carry(op_q)) begin
            carry_d[id_q] = alu_carry;
        end
    end
`else
    logic carry_q, carry_d;

    assign alu_cin = carry_q;

    always_comb begin
        carry_d = carry_q;
        if (last_exec && sets_carry(op_q)) begin
            carry_d = alu_carry;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rsp_id_d    = rsp_id_q;
        rsp_l_d     = rsp_l_q;
        rsp_h_d     = rsp_h_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_sign_d  = rsp_sign_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    id_d    = gnt[1];
                    op_d    = gnt[1] ? bus.req1_op : bus.req0_op;
                    a_d     = gnt[1] ? bus.req1_a  : bus.req0_a;
                    b_d     = gnt[1] ? bus.req1_b  : bus.req0_b;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_d   = is_mul(op_q) ? CNT_W'(MUL_CYCLES) : CNT_W'(EXEC_CYCLES);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last_exec) begin
                    rsp_id_d    = id_q;
                    rsp_l_d     = alu_res_l;
                    rsp_h_d     = alu_res_h;
                    rsp_carry_d = alu_carry;
                    rsp_zero_d  = alu_zero;
                    rsp_sign_d  = alu_sign;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        alu_rst_d   = (state_d != ST_EXEC);
        alu_en_d    = (state_d == ST_EXEC);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            alu_rst_q   <= 1'b1;
            alu_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_l_q     <= '0;
            rsp_h_q     <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_sign_q  <= 1'b0;
            carry_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            alu_rst_q   <= alu_rst_d;
            alu_en_q    <= alu_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_l_q     <= rsp_l_d;
            rsp_h_q     <= rsp_h_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_sign_q  <= rsp_sign_d;
            carry_q     <= carry_d;
        end
    end

    assign alu_rst       = alu_rst_q;
    assign alu_en        = alu_en_q;
    assign alu_op        = op_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_l     = rsp_l_q;
    assign bus.rsp_h     = rsp_h_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_sign  = rsp_sign_q;

endmodule
